// File: rtl/nios2_soc_sysid_pkg.sv
// Shared constants for the extended system-ID slave: word map, CAPS layout,
// CTRL bit positions and reset values.
package nios2_soc_sysid_pkg;

   localparam int unsigned W_ID         = 0;
   localparam int unsigned W_TIMESTAMP  = 1;
   localparam int unsigned W_CAPS       = 2;
   localparam int unsigned W_SCRATCH    = 3;
   localparam int unsigned W_UPTIME_LO  = 4;
   localparam int unsigned W_UPTIME_HI  = 5;
   localparam int unsigned W_CTRL       = 6;
   localparam int unsigned W_IRQ_CMP    = 7;
   localparam int unsigned W_IRQ_STATUS = 8;

   localparam int CAPS_VER_LSB = 0;
   localparam int CAPS_IRQ_BIT = 16;
   localparam int CAPS_LAT_LSB = 20;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_CLR_BIT = 1;

   localparam logic        RST_CTRL_EN = 1'b1;
   localparam logic [31:0] RST_SCRATCH = 32'h0000_0000;
   localparam logic [31:0] RST_IRQ_CMP = 32'hFFFF_FFFF;
   localparam logic [63:0] RST_UPTIME  = 64'h0;

   // CAPS word: version in the low half, IRQ presence flag, read latency nibble.
   function automatic logic [31:0] make_caps(input logic [15:0] version,
                                             input logic        irq_present,
                                             input int          latency);
      logic [31:0] caps;
      caps                        = '0;
      caps[CAPS_VER_LSB +: 16]    = version;
      caps[CAPS_IRQ_BIT]          = irq_present;
      caps[CAPS_LAT_LSB +: 4]     = 4'(latency);
      return caps;
   endfunction

endpackage

// File: rtl/nios2_soc_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the system-ID block (no waitrequest).
interface nios2_soc_sysid_ext_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic [31:0]       readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/nios2_soc_sysid_rdpipe.sv
// Fixed-latency read return pipeline: valid and data shift together,
// synchronous flush drops everything in flight and zeroes the output.
module nios2_soc_sysid_rdpipe #(
   parameter int LATENCY = 1
) (
   input  logic        clock,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        out_valid,
   output logic [31:0] out_data
);
   logic [LATENCY-1:0] vld;
   logic [31:0]        dat [LATENCY];

   // Shift stage by stage; data is zeroed on idle slots so readdata rests at 0.
   always_ff @(posedge clock) begin
      if (flush) begin
         vld <= '0;
         for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
      end else begin
         vld[0] <= in_valid;
         dat[0] <= in_valid ? in_data : 32'h0;
         for (int i = 1; i < LATENCY; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   assign out_valid = vld[LATENCY-1];
   assign out_data  = dat[LATENCY-1];
endmodule

// File: rtl/nios2_soc_sysid_ext.sv
// Extended system-ID slave: ID/timestamp at words 0/1, CAPS, scratch,
// 64-bit uptime with coherent LO->HI snapshot, CTRL, optional compare IRQ.
// Optional feature macro: NIOS2_SOC_SYSID_IRQ_EN (adds IRQ_CMP/IRQ_STATUS, drives irq).
module nios2_soc_sysid_ext
   import nios2_soc_sysid_pkg::*;
#(
   parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP    = 32'd1536242190,
   parameter logic [15:0] VERSION      = 16'h0002,
   parameter int          ADDR_W       = 4,
   parameter int          READ_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   nios2_soc_sysid_ext_if.slave  bus,
   output logic                  irq
);
`ifdef NIOS2_SOC_SYSID_IRQ_EN
   localparam logic IRQ_PRESENT = 1'b1;
`else
   localparam logic IRQ_PRESENT = 1'b0;
`endif
   localparam logic [31:0] CAPS = make_caps(VERSION, IRQ_PRESENT, READ_LATENCY);

   logic [ADDR_W-1:0] addr;
   int unsigned       word_idx;
   logic [31:0]       scratch;
   logic              ctrl_en;
   logic [63:0]       uptime;
   logic [31:0]       uptime_hi_shadow;
   logic [31:0]       rd_mux;
   logic              wr_scratch;
   logic              wr_ctrl;
   logic              ctrl_clr;
   logic              rd_lo;

   assign addr     = bus.address;
   assign word_idx = 32'(addr);

   assign wr_scratch = bus.write && (word_idx == W_SCRATCH);
   assign wr_ctrl    = bus.write && (word_idx == W_CTRL) && bus.byteenable[0];
   assign ctrl_clr   = wr_ctrl && bus.writedata[CTRL_CLR_BIT];
   assign rd_lo      = bus.read && (word_idx == W_UPTIME_LO);

   // Scratch register with per-byte write lanes.
   always_ff @(posedge clock) begin
      if (reset) begin
         scratch <= RST_SCRATCH;
      end else if (wr_scratch) begin
         for (int b = 0; b < 4; b++)
            if (bus.byteenable[b]) scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
      end
   end

   // CTRL enable bit; the clear bit is a write-only pulse and is not stored.
   always_ff @(posedge clock) begin
      if (reset)        ctrl_en <= RST_CTRL_EN;
      else if (wr_ctrl) ctrl_en <= bus.writedata[CTRL_EN_BIT];
   end

   // Uptime counter: clear wins over increment, wraps silently.
   always_ff @(posedge clock) begin
      if (reset)         uptime <= RST_UPTIME;
      else if (ctrl_clr) uptime <= 64'h0;
      else if (ctrl_en)  uptime <= uptime + 64'h1;
   end

   // Reading the low word freezes the matching high word for the next HI read.
   always_ff @(posedge clock) begin
      if (reset)      uptime_hi_shadow <= 32'h0;
      else if (rd_lo) uptime_hi_shadow <= uptime[63:32];
   end

`ifdef NIOS2_SOC_SYSID_IRQ_EN
   logic [31:0] irq_cmp;
   logic        irq_sts;
   logic        irq_set;
   logic        irq_clr;

   assign irq_set = ctrl_en && (uptime[31:0] == irq_cmp);
   assign irq_clr = bus.write && (word_idx == W_IRQ_STATUS) &&
                    bus.byteenable[0] && bus.writedata[0];

   // Compare value, per-byte writable.
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_cmp <= RST_IRQ_CMP;
      end else if (bus.write && (word_idx == W_IRQ_CMP)) begin
         for (int b = 0; b < 4; b++)
            if (bus.byteenable[b]) irq_cmp[8*b +: 8] <= bus.writedata[8*b +: 8];
      end
   end

   // Sticky status, write-1-to-clear; a new match in the same cycle keeps it set.
   always_ff @(posedge clock) begin
      if (reset) irq_sts <= 1'b0;
      else       irq_sts <= irq_set | (irq_sts & ~irq_clr);
   end

   assign irq = irq_sts;
`else
   assign irq = 1'b0;
`endif

   // Read data mux, sampled in the read cycle (pre-write state).
   always_comb begin
      rd_mux = '0;
      case (word_idx)
         W_ID:         rd_mux = SYSTEM_ID;
         W_TIMESTAMP:  rd_mux = TIMESTAMP;
         W_CAPS:       rd_mux = CAPS;
         W_SCRATCH:    rd_mux = scratch;
         W_UPTIME_LO:  rd_mux = uptime[31:0];
         W_UPTIME_HI:  rd_mux = uptime_hi_shadow;
         W_CTRL:       rd_mux[CTRL_EN_BIT] = ctrl_en;
`ifdef NIOS2_SOC_SYSID_IRQ_EN
         W_IRQ_CMP:    rd_mux = irq_cmp;
         W_IRQ_STATUS: rd_mux[0] = irq_sts;
`endif
         default:      rd_mux = '0;
      endcase
   end

   nios2_soc_sysid_rdpipe #(
      .LATENCY (READ_LATENCY)
   ) u_rdpipe (
      .clock     (clock),
      .flush     (reset),
      .in_valid  (bus.read),
      .in_data   (rd_mux),
      .out_valid (bus.readdatavalid),
      .out_data  (bus.readdata)
   );
endmodule

// File: tb/tb_nios2_soc_sysid_ext.sv
// Directed bench for nios2_soc_sysid_ext; IRQ checks follow NIOS2_SOC_SYSID_IRQ_EN.
module tb_nios2_soc_sysid_ext;
   import nios2_soc_sysid_pkg::*;

   localparam int          LAT    = 1;
   localparam logic [31:0] SYS_ID = 32'hCAFE_0123;
   localparam logic [31:0] TS     = 32'd1536242190;
`ifdef NIOS2_SOC_SYSID_IRQ_EN
   localparam logic [31:0] CAPS_EXP = 32'h0011_0002;
`else
   localparam logic [31:0] CAPS_EXP = 32'h0010_0002;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic irq;
   int   n_cmp = 0;
   int   n_bad = 0;

   nios2_soc_sysid_ext_if #(.ADDR_W(4)) bus ();

   nios2_soc_sysid_ext #(
      .SYSTEM_ID    (SYS_ID),
      .TIMESTAMP    (TS),
      .VERSION      (16'h0002),
      .ADDR_W       (4),
      .READ_LATENCY (LAT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .irq   (irq)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] be);
      bus.address    = 4'(a);
      bus.writedata  = d;
      bus.byteenable = be;
      bus.write      = 1'b1;
      @(negedge clock);
      bus.write      = 1'b0;
   endtask

   task automatic bus_read(input int a, output logic [31:0] d,
                           input bit also_write = 1'b0, input logic [31:0] wd = 32'h0);
      int cyc;
      bus.address    = 4'(a);
      bus.read       = 1'b1;
      bus.write      = also_write;
      bus.writedata  = wd;
      bus.byteenable = 4'hF;
      @(negedge clock);
      bus.read  = 1'b0;
      bus.write = 1'b0;
      cyc = 1;
      while (!bus.readdatavalid && cyc < 8) begin
         @(negedge clock);
         cyc++;
      end
      chk($sformatf("latency_w%0d", a), 64'(cyc), 64'(LAT));
      d = bus.readdata;
   endtask

   task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      chk(tag, 64'(d), 64'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] a_val, b_val, d;
      logic [31:0] got[$];
      logic [31:0] snap_exp[4];
      int          snap_addr[4];
      int          valids, issued, n;
      bit          rst_done;

      bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
      bus.writedata = '0; bus.byteenable = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      chk("rst_rdv",   64'(bus.readdatavalid), 64'd0);
      chk("rst_rdata", 64'(bus.readdata), 64'd0);
      chk("rst_irq",   64'(irq), 64'd0);

      rd_chk("id",   0, SYS_ID);
      rd_chk("ts",   1, TS);
      rd_chk("caps", 2, CAPS_EXP);
      @(negedge clock);
      chk("rdv_one_pulse", 64'(bus.readdatavalid), 64'd0);

      rd_chk("scratch_rst", 3, 32'h0);
      rd_chk("ctrl_rst",    6, 32'h1);
      bus_write(3, 32'hA5A5_5A5A, 4'b0101);
      rd_chk("scratch_be",  3, 32'h00A5_005A);

      bus_write(0, 32'hFFFF_FFFF, 4'hF);
      rd_chk("id_read_only", 0, SYS_ID);
      bus_write(9, 32'h1111_2222, 4'hF);
      rd_chk("unmapped_9",  9,  32'h0);
      rd_chk("unmapped_15", 15, 32'h0);
`ifndef NIOS2_SOC_SYSID_IRQ_EN
      bus_write(7, 32'h0000_0032, 4'hF);
      rd_chk("unmapped_7", 7, 32'h0);
      rd_chk("unmapped_8", 8, 32'h0);
`endif

      bus_read(3, d, 1'b1, 32'h1234_5678);
      chk("rw_same_cycle_old", 64'(d), 64'h00A5_005A);
      rd_chk("rw_same_cycle_new", 3, 32'h1234_5678);

      bus_write(6, 32'h0, 4'hF);
      bus_read(4, a_val);
      repeat (100) @(negedge clock);
      bus_read(4, b_val);
      chk("frozen", 64'(b_val), 64'(a_val));
      rd_chk("ctrl_off", 6, 32'h0);

      bus_write(6, 32'h3, 4'hF);
      rd_chk("clear_zero",   4, 32'h0);
      rd_chk("counts_again", 4, 32'(LAT));
      rd_chk("ctrl_clr_rd0", 6, 32'h1);

      bus_write(6, 32'h0, 4'hF);
      force dut.uptime = 64'h0000_0000_FFFF_FFFE;
      @(negedge clock);
      release dut.uptime;
      bus_write(6, 32'h1, 4'hF);
      snap_addr = '{4, 5, 4, 5};
      snap_exp  = '{32'hFFFF_FFFE, 32'h0, 32'h0, 32'h1};
      for (int c = 0; c < 4 + LAT + 1; c++) begin
         if (c < 4) begin
            bus.address = 4'(snap_addr[c]);
            bus.read    = 1'b1;
         end else begin
            bus.read = 1'b0;
         end
         @(negedge clock);
         if (bus.readdatavalid) got.push_back(bus.readdata);
      end
      chk("snap_count", 64'(got.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("snap_%0d", i),
             64'((i < got.size()) ? got[i] : 32'hDEAD_BEEF), 64'(snap_exp[i]));

      valids = 0; issued = 0; rst_done = 1'b0;
      for (int c = 0; c < 20 && !rst_done; c++) begin
         if (issued < 4) begin
            bus.address = 4'd0;
            bus.read    = 1'b1;
            issued++;
         end else begin
            bus.read = 1'b0;
         end
         @(negedge clock);
         if (bus.readdatavalid) valids++;
         if (valids == 2) begin
            bus.read = 1'b0;
            reset    = 1'b1;
            rst_done = 1'b1;
         end
      end
      chk("reset_reached", 64'(rst_done), 64'd1);
      @(negedge clock);
      reset = 1'b0;
      n = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.readdatavalid) n++;
         @(negedge clock);
      end
      chk("no_rdv_after_rst",  64'(n), 64'd0);
      chk("rdata_after_rst",   64'(bus.readdata), 64'd0);
      chk("irq_after_rst",     64'(irq), 64'd0);
      rd_chk("scratch_after_rst", 3, 32'h0);
      rd_chk("ctrl_after_rst",    6, 32'h1);

`ifdef NIOS2_SOC_SYSID_IRQ_EN
      rd_chk("irq_cmp_rst", 7, 32'hFFFF_FFFF);
      bus_write(7, 32'd50, 4'hF);
      bus_write(6, 32'h3, 4'hF);
      n = 0;
      while (!irq && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("irq_delay", 64'(n), 64'd51);
      repeat (10) @(negedge clock);
      chk("irq_sticky", 64'(irq), 64'd1);
      rd_chk("irq_status_set", 8, 32'h1);
      bus_write(8, 32'h1, 4'hF);
      chk("irq_cleared", 64'(irq), 64'd0);
      rd_chk("irq_status_clr", 8, 32'h0);
`else
      repeat (60) @(negedge clock);
      chk("irq_tied_low", 64'(irq), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
